// File: rtl/riscv_mem_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 codes, FSM encoding,
// byte-enable patterns and the access legality rule.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } mau_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unsigned store sizes (100/101) have no meaning, so they are rejected like 011/11x.
    function automatic logic access_legal(input logic is_store, input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic legal;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !offset[0];
            F3_W:    legal = (offset == 2'b00);
            F3_BU:   legal = !is_store;
            F3_HU:   legal = !is_store && !offset[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/half/word from a 32-bit read word and sign- or zero-extends it.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = lanes[a];
    assign half_sel = a[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: data-memory handshake FSM, store packing and the MEM/WB register.
module mem_access_unit
    import riscv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] rs2Data_mem,
    input  logic [4:0]  rd_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        misalign_exc,
    output logic        MemtoReg_wb,
    output logic        RegWrite_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] memDout_wb,
    output logic [31:0] ALUResult_wb
);

    mau_state_t  state_reg;
    logic        mem_op;
    logic        is_store;
    logic        legal;
    logic [1:0]  offset;
    logic [31:0] load_data;
    logic [31:0] pack_wdata;
    logic [3:0]  pack_be;

    assign mem_op   = MemRead_mem | MemWrite_mem;
    assign is_store = MemWrite_mem;
    assign offset   = ALUResult_mem[1:0];
    assign legal    = access_legal(is_store, funct3_mem, offset);

    // The _mem operands are held upstream for the whole access, so the live offset is valid in WAIT.
    load_align u_load_align (
        .rdata  (dmem_rdata),
        .a      (offset),
        .funct3 (funct3_mem),
        .data   (load_data)
    );

    always_comb begin
        pack_wdata = rs2Data_mem;
        pack_be    = BE_WORD;
        case (funct3_mem)
            F3_B: begin
                pack_wdata = {4{rs2Data_mem[7:0]}};
                pack_be    = BE_BYTE0 << offset;
            end
            F3_H: begin
                pack_wdata = {2{rs2Data_mem[15:0]}};
                pack_be    = offset[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: begin
                pack_wdata = rs2Data_mem;
                pack_be    = BE_WORD;
            end
        endcase
    end

    always_comb begin
        stall_mem = 1'b0;
        case (state_reg)
            IDLE:    stall_mem = mem_op & legal;
            REQ:     stall_mem = !(dmem_gnt & dmem_we);
            WAIT:    stall_mem = !dmem_rvalid;
            default: stall_mem = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= BE_NONE;
            misalign_exc <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            RegWrite_wb  <= 1'b0;
            rd_wb        <= '0;
            memDout_wb   <= '0;
            ALUResult_wb <= '0;
        end else begin
            // Default is a bubble; only completing cycles overwrite it.
            misalign_exc <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            RegWrite_wb  <= 1'b0;
            rd_wb        <= '0;
            memDout_wb   <= '0;
            ALUResult_wb <= '0;
            case (state_reg)
                IDLE: begin
                    if (!mem_op) begin
                        MemtoReg_wb  <= MemtoReg_mem;
                        RegWrite_wb  <= RegWrite_mem;
                        rd_wb        <= rd_mem;
                        ALUResult_wb <= ALUResult_mem;
                    end else if (legal) begin
                        state_reg  <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {ALUResult_mem[31:2], 2'b00};
                        dmem_wdata <= is_store ? pack_wdata : '0;
                        dmem_be    <= is_store ? pack_be : BE_NONE;
                    end else begin
                        misalign_exc <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        dmem_be    <= BE_NONE;
                        if (dmem_we) begin
                            state_reg    <= IDLE;
                            MemtoReg_wb  <= MemtoReg_mem;
                            RegWrite_wb  <= RegWrite_mem;
                            rd_wb        <= rd_mem;
                            ALUResult_wb <= ALUResult_mem;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_reg    <= IDLE;
                        MemtoReg_wb  <= MemtoReg_mem;
                        RegWrite_wb  <= RegWrite_mem;
                        rd_wb        <= rd_mem;
                        ALUResult_wb <= ALUResult_mem;
                        memDout_wb   <= load_data;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random ops against a rule-level model,
// and reset-during-access sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] ALUResult_mem, rs2Data_mem;
    logic [4:0]  rd_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_mem, misalign_exc;
    logic        MemtoReg_wb, RegWrite_wb;
    logic [4:0]  rd_wb;
    logic [31:0] memDout_wb, ALUResult_wb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
        .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
        .funct3_mem(funct3_mem), .ALUResult_mem(ALUResult_mem),
        .rs2Data_mem(rs2Data_mem), .rd_mem(rd_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .misalign_exc(misalign_exc),
        .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb),
        .memDout_wb(memDout_wb), .ALUResult_wb(ALUResult_wb)
    );

    typedef struct {
        logic        mr, mw, mtr, rw;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic [4:0]  rd;
        int          gnt_dly, rv_dly;
    } op_t;

    typedef struct {
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        int          stalls;
        logic        exc, rw, mtr, full;
        logic [4:0]  rd;
        logic [31:0] alu, dout;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t exp;
    } vec_t;

    typedef struct {
        logic        req, we, stable, bubble_ok, timeout, exc, exc_after;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        int          stalls;
        logic        rw, mtr;
        logic [4:0]  rd;
        logic [31:0] alu, dout;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        MemRead_mem = 1'b0; MemWrite_mem = 1'b0; MemtoReg_mem = 1'b0; RegWrite_mem = 1'b0;
        funct3_mem = 3'd0; ALUResult_mem = '0; rs2Data_mem = '0; rd_mem = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    // Rule-level reference: size/sign from funct3, legality by address modulo size,
    // extraction by shift and modulo, sign extension by subtracting 2^bits.
    function automatic exp_t model(input op_t op);
        exp_t    e;
        int      size;
        longint  v, lim;
        int      a;
        e = '{default: 0};
        a = int'(op.addr % 4);
        if (!(op.mr || op.mw)) begin
            e.rw = op.rw; e.mtr = op.mtr; e.full = 1'b1; e.rd = op.rd; e.alu = op.addr;
            return e;
        end
        case (op.f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || (op.mw && op.f3 >= 3'd4) || (op.addr % size) != 0) begin
            e.exc = 1'b1;
            return e;
        end
        lim = 64'd1 << (8 * size);
        e.req = 1'b1; e.we = op.mw; e.addr = op.addr - 32'(a);
        e.rw = op.rw; e.mtr = op.mtr; e.full = 1'b1; e.rd = op.rd; e.alu = op.addr;
        if (op.mw) begin
            v = longint'(op.wd) % lim;
            if (size == 1)      e.wdata = 32'(v * 64'h0101_0101);
            else if (size == 2) e.wdata = 32'(v * 64'h0001_0001);
            else                e.wdata = 32'(v);
            e.be = 4'(((1 << size) - 1) << a);
            e.stalls = 1 + op.gnt_dly;
        end else begin
            v = (longint'(op.rdata) >> (8 * a)) % lim;
            if (op.f3 < 3'd4 && v >= lim / 2) v = v - lim;
            e.dout = 32'(v);
            e.stalls = 2 + op.gnt_dly + op.rv_dly;
        end
        return e;
    endfunction

    // Drives one instruction, plays the memory side (with rvalid noise during REQ and gnt
    // noise during WAIT), and records what the DUT did.
    task automatic do_op(input op_t op, output res_t r);
        int   req_cnt, wait_cnt;
        logic granted, done;
        r = '{default: 0};
        r.stable = 1'b1; r.bubble_ok = 1'b1;
        req_cnt = 0; wait_cnt = 0; granted = 1'b0; done = 1'b0;
        @(negedge clk);
        MemRead_mem = op.mr; MemWrite_mem = op.mw; MemtoReg_mem = op.mtr; RegWrite_mem = op.rw;
        funct3_mem = op.f3; ALUResult_mem = op.addr; rs2Data_mem = op.wd; rd_mem = op.rd;
        dmem_rdata = op.rdata;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0 && (RegWrite_wb || MemtoReg_wb)) r.bubble_ok = 1'b0;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (dmem_req) begin
                if (!r.req) begin
                    r.req = 1'b1; r.we = dmem_we; r.addr = dmem_addr; r.wdata = dmem_wdata; r.be = dmem_be;
                end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} != {r.we, r.addr, r.wdata, r.be}) begin
                    r.stable = 1'b0;
                end
                dmem_gnt = (req_cnt >= op.gnt_dly);
                dmem_rvalid = 1'b1;
                req_cnt++;
            end else if (granted) begin
                dmem_rvalid = (wait_cnt >= op.rv_dly);
                dmem_gnt = !dmem_rvalid;
                wait_cnt++;
            end
            #1;
            if (stall_mem) r.stalls++;
            else done = 1'b1;
            if (dmem_req && dmem_gnt) granted = 1'b1;
            @(negedge clk);
        end
        r.timeout = !done;
        r.exc = misalign_exc;
        r.rw = RegWrite_wb; r.mtr = MemtoReg_wb; r.rd = rd_wb; r.alu = ALUResult_wb; r.dout = memDout_wb;
        set_nop();
        @(negedge clk);
        r.exc_after = misalign_exc;
    endtask

    task automatic check_op(input string tag, input op_t op, input exp_t e);
        res_t r;
        do_op(op, r);
        $display("%s: mr=%0b mw=%0b f3=%0d addr=%h gnt_dly=%0d rv_dly=%0d -> req=%0b stalls=%0d exc=%0b dout=%h",
                 tag, op.mr, op.mw, op.f3, op.addr, op.gnt_dly, op.rv_dly, r.req, r.stalls, r.exc, r.dout);
        chk({tag, ".timeout"}, 32'(r.timeout), 32'd0);
        chk({tag, ".req"}, 32'(r.req), 32'(e.req));
        chk({tag, ".stalls"}, 32'(r.stalls), 32'(e.stalls));
        chk({tag, ".exc"}, 32'(r.exc), 32'(e.exc));
        chk({tag, ".exc_pulse_end"}, 32'(r.exc_after), 32'd0);
        chk({tag, ".bubbles"}, 32'(r.bubble_ok), 32'd1);
        chk({tag, ".rw_wb"}, 32'(r.rw), 32'(e.rw));
        chk({tag, ".mtr_wb"}, 32'(r.mtr), 32'(e.mtr));
        if (e.req) begin
            chk({tag, ".addr"}, r.addr, e.addr);
            chk({tag, ".we"}, 32'(r.we), 32'(e.we));
            chk({tag, ".stable"}, 32'(r.stable), 32'd1);
            if (e.we) begin
                chk({tag, ".wdata"}, r.wdata, e.wdata);
                chk({tag, ".be"}, 32'(r.be), 32'(e.be));
            end
        end
        if (e.full) begin
            chk({tag, ".rd_wb"}, 32'(r.rd), 32'(e.rd));
            chk({tag, ".alu_wb"}, r.alu, e.alu);
            chk({tag, ".dout_wb"}, r.dout, e.dout);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
        chk({tag, ".dmem_addr"}, dmem_addr, 32'd0);
        chk({tag, ".dmem_wdata"}, dmem_wdata, 32'd0);
        chk({tag, ".dmem_be"}, 32'(dmem_be), 32'd0);
        chk({tag, ".stall"}, 32'(stall_mem), 32'd0);
        chk({tag, ".exc"}, 32'(misalign_exc), 32'd0);
        chk({tag, ".wb"}, {25'(0), MemtoReg_wb, RegWrite_wb, rd_wb}, 32'd0);
        chk({tag, ".dout_wb"}, memDout_wb, 32'd0);
        chk({tag, ".alu_wb"}, ALUResult_wb, 32'd0);
    endtask

    vec_t        tbl [12];
    logic [2:0]  ld_codes [10];
    logic [2:0]  st_codes [7];

    initial begin
        op_t  op;
        exp_t e;

        tbl[0]  = '{'{0,0,0,1,3'd0,32'h0000_1234,32'h0,32'h0,5'd5,0,0},
                    '{0,0,32'h0,32'h0,4'h0,0,0,1,0,1,5'd5,32'h0000_1234,32'h0}};
        tbl[1]  = '{'{1,0,1,1,3'd0,32'h0000_0103,32'h0,32'h80AB_CDEF,5'd7,0,1},
                    '{1,0,32'h100,32'h0,4'h0,3,0,1,1,1,5'd7,32'h103,32'hFFFF_FF80}};
        tbl[2]  = '{'{0,1,0,0,3'd1,32'h0000_0202,32'h1234_ABCD,32'h0,5'd0,3,0},
                    '{1,1,32'h200,32'hABCD_ABCD,4'b1100,4,0,0,0,1,5'd0,32'h202,32'h0}};
        tbl[3]  = '{'{1,0,1,1,3'd2,32'h0000_0101,32'h0,32'h0,5'd3,0,0},
                    '{0,0,32'h0,32'h0,4'h0,0,1,0,0,0,5'd0,32'h0,32'h0}};
        tbl[4]  = '{'{1,0,1,1,3'd5,32'h0000_0002,32'h0,32'h8001_0000,5'd9,0,0},
                    '{1,0,32'h0,32'h0,4'h0,2,0,1,1,1,5'd9,32'h2,32'h0000_8001}};
        tbl[5]  = '{'{1,0,1,1,3'd1,32'h0000_0002,32'h0,32'h8001_0000,5'd10,0,0},
                    '{1,0,32'h0,32'h0,4'h0,2,0,1,1,1,5'd10,32'h2,32'hFFFF_8001}};
        tbl[6]  = '{'{0,1,0,0,3'd0,32'h0000_0301,32'h0000_00CD,32'h0,5'd0,0,0},
                    '{1,1,32'h300,32'hCDCD_CDCD,4'b0010,1,0,0,0,1,5'd0,32'h301,32'h0}};
        tbl[7]  = '{'{0,1,0,0,3'd2,32'h0000_0300,32'hDEAD_BEEF,32'h0,5'd0,1,0},
                    '{1,1,32'h300,32'hDEAD_BEEF,4'b1111,2,0,0,0,1,5'd0,32'h300,32'h0}};
        tbl[8]  = '{'{1,0,1,1,3'd3,32'h0000_0000,32'h0,32'h0,5'd4,0,0},
                    '{0,0,32'h0,32'h0,4'h0,0,1,0,0,0,5'd0,32'h0,32'h0}};
        tbl[9]  = '{'{1,0,1,1,3'd4,32'h0000_0101,32'h0,32'h0000_F200,5'd11,0,0},
                    '{1,0,32'h100,32'h0,4'h0,2,0,1,1,1,5'd11,32'h101,32'h0000_00F2}};
        tbl[10] = '{'{1,0,1,1,3'd2,32'h0000_0400,32'h0,32'h89AB_CDEF,5'd12,2,3},
                    '{1,0,32'h400,32'h0,4'h0,7,0,1,1,1,5'd12,32'h400,32'h89AB_CDEF}};
        tbl[11] = '{'{0,1,0,0,3'd1,32'h0000_0203,32'h1111_2222,32'h0,5'd0,0,0},
                    '{0,0,32'h0,32'h0,4'h0,0,1,0,0,0,5'd0,32'h0,32'h0}};

        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6, 3'd7};
        st_codes = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};

        rst_n = 1'b0;
        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp);

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            op = '{default: 0};
            op.mr = (kind == 1);
            op.mw = (kind == 2);
            op.mtr = (kind == 1) ? 1'b1 : 1'b0;
            op.rw = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            op.f3 = (kind == 2) ? st_codes[$urandom_range(0, 6)] : ld_codes[$urandom_range(0, 9)];
            op.addr = $urandom;
            if ($urandom_range(0, 1) == 1) op.addr[1:0] = 2'b00;
            op.wd = $urandom;
            op.rdata = $urandom;
            op.rd = 5'($urandom_range(0, 31));
            op.gnt_dly = int'($urandom_range(0, 3));
            op.rv_dly = int'($urandom_range(0, 3));
            e = model(op);
            check_op($sformatf("rnd%0d", i), op, e);
        end

        // Reset while waiting for rvalid, then a late rvalid must be ignored.
        @(negedge clk);
        MemRead_mem = 1'b1; MemtoReg_mem = 1'b1; RegWrite_mem = 1'b1; funct3_mem = 3'd2;
        ALUResult_mem = 32'h500; rd_mem = 5'd6;
        @(negedge clk);
        chk("rstwait.req_in_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("rstwait.stall_in_wait", 32'(stall_mem), 32'd1);
        rst_n = 1'b0;
        set_nop();
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rstwait");
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstwait.late_rvalid_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("rstwait.late_rvalid_dout", memDout_wb, 32'd0);
        chk("rstwait.late_rvalid_rw", 32'(RegWrite_wb), 32'd0);
        $display("rstwait: late rvalid after reset, dout=%h", memDout_wb);

        // Reset while the request is still waiting for gnt drops dmem_req at that edge.
        @(negedge clk);
        MemWrite_mem = 1'b1; funct3_mem = 3'd2; ALUResult_mem = 32'h600; rs2Data_mem = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rstreq.req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        set_nop();
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rstreq");
        $display("rstreq: reset during REQ, dmem_req=%0b", dmem_req);

        // Normal operation resumes after the mid-access reset.
        check_op("post_reset", tbl[4].op, tbl[4].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit of the five-stage RISC-V pipeline. It takes the EX/MEM operands, runs a valid/grant/rvalid handshake with data memory, aligns and sign- or zero-extends load data, and registers the results into the MEM/WB register. Its outputs `MemtoReg_wb`, `memDout_wb` and `ALUResult_wb` feed the writeback select. It stalls the upstream pipeline while a memory access is outstanding.

## Interface
- No parameters. Data and address are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `MemRead_mem`, `MemWrite_mem`, `MemtoReg_mem`, `RegWrite_mem` in 1 each: control from EX/MEM.
- `funct3_mem` in 3: access size and sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `ALUResult_mem` in 32: effective address, or the ALU result for non-memory instructions.
- `rs2Data_mem` in 32: store data.
- `rd_mem` in 5: destination register.
- `dmem_req` out 1, `dmem_we` out 1: request, and write enable.
- `dmem_addr` out 32: word-aligned address, bits [1:0] = 0.
- `dmem_wdata` out 32, `dmem_be` out 4: store data and byte enables.
- `dmem_gnt` in 1, `dmem_rvalid` in 1, `dmem_rdata` in 32: memory response.
- `stall_mem` out 1: combinational; upstream holds all `_mem` inputs while it is high.
- `misalign_exc` out 1: one-cycle pulse.
- `MemtoReg_wb`, `RegWrite_wb` out 1 each; `rd_wb` out 5; `memDout_wb` out 32; `ALUResult_wb` out 32: MEM/WB register outputs.

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE, no memory op.** WB register loads the `_mem` values. `memDout_wb` = 0. `stall_mem` = 0.
- **IDLE, aligned load or store.** `stall_mem` = 1. WB register loads a bubble (`RegWrite_wb` = 0, `MemtoReg_wb` = 0). Next state is REQ.
- **IDLE, misaligned or illegal access.** No request is issued and `stall_mem` = 0. WB register loads a bubble. `misalign_exc` pulses in the following cycle.
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0.
  - Illegal: funct3 011, 110 or 111.
- **REQ.** `dmem_req` = 1 and all `dmem_*` outputs stay stable until `dmem_gnt`.
  - Store granted: the access completes this cycle. `stall_mem` = 0, WB register loads `_mem` controls, next state is IDLE.
  - Load granted: `stall_mem` stays 1, next state is WAIT.
  - `dmem_rvalid` is ignored in REQ.
- **WAIT.** `dmem_req` = 0. `stall_mem` = 1 until `dmem_rvalid`.
  - On `dmem_rvalid`: `stall_mem` = 0, WB register loads the aligned data into `memDout_wb` plus the `_mem` controls, next state is IDLE.
  - `dmem_gnt` is ignored in WAIT.
- **Bubbles.** Every stall cycle loads a bubble into the WB register.
- **Load alignment (a = addr[1:0]).**
  - LB/LBU: byte `rdata[8a+7:8a]`, sign- or zero-extended.
  - LH/LHU: half `rdata[16·a[1]+15 : 16·a[1]]`, sign- or zero-extended.
  - LW: `rdata` unchanged.
- **Store packing.**
  - SB: wdata = byte replicated 4×, be = 1 << a.
  - SH: wdata = half replicated 2×, be = 0011 if a[1] = 0, else 1100.
  - SW: wdata = `rs2Data_mem`, be = 1111.
- **Reset** (`rst_n` low at a rising edge): state returns to IDLE.
  - Every output is 0, including `dmem_req`, `stall_mem` and the whole WB register.
  - Reset mid-access drops `dmem_req` at that edge.
  - An `rvalid` arriving after reset in IDLE is ignored.

## Timing
- Non-memory instruction: 1 cycle, no stall.
- Store: minimum 2 cycles (detect, then REQ with `gnt`); `stall_mem` is high for 1 cycle.
- Load: minimum 3 cycles (IDLE, REQ with `gnt`, WAIT with `rvalid`). Data appears on `memDout_wb` after the completing edge.
- Each cycle of `gnt` delay, or of `rvalid` delay, adds exactly 1 stall cycle.
- `dmem_*` outputs are registered and change only at clock edges.
- `stall_mem` is decoded combinationally from the current state and the response inputs.

## Structure
- **Shared package `riscv_mem_pkg`:**
  - funct3 load/store constants;
  - FSM state encoding: IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10;
  - byte-enable patterns.
- **Sub-module `load_align`:** combinational. Inputs: `rdata`, a, funct3. Output: the aligned, extended 32-bit result.
- The FSM, store packing and the WB register stay in `mem_access_unit`.

## Test plan
- **ADD.** `ALUResult_mem` = 0x0000_1234, `RegWrite_mem` = 1, `rd_mem` = 5 → after 1 edge: `ALUResult_wb` = 0x1234, `rd_wb` = 5, `RegWrite_wb` = 1; `stall_mem` never asserted.
- **LB** from addr 0x103, `rdata` = 0x80AB_CDEF, `gnt` in the first REQ cycle, `rvalid` 2 cycles later → `memDout_wb` = 0xFFFF_FF80, `MemtoReg_wb` = 1; `stall_mem` high for 3 cycles.
- **SH** of 0x1234_ABCD to addr 0x202, `gnt` delayed 3 cycles → `dmem_addr` = 0x200, `be` = 1100, `wdata` = 0xABCD_ABCD held stable until `gnt`; `RegWrite_wb` = 0.
- **LW** to 0x101 → no `dmem_req`; `misalign_exc` pulses 1 cycle; `stall_mem` = 0.
- **LHU** from addr 0x002, `rdata` = 0x8001_0000 → `memDout_wb` = 0x0000_8001.
- **Reset in WAIT**, then `rvalid` → `dmem_req` = 0, state IDLE, all outputs 0; the late `rvalid` leaves `memDout_wb` = 0.
